ov7670_dvp_emulator: RTL and testbench

Transmitter side of the OV7670 parallel camera (DVP) interface: it generates pclk, vsync, href and 8-bit RGB565 byte data exactly as the sensor drives them. It replaces the camera so the capture and display path can be brought up and regression-tested without a sensor. Frames are synthetic test patterns. It sits on the board-level camera pins or in the testbench in front of the camera controller.

---
 rtl/ov7670_pkg.sv | 48 ++++
 rtl/ov7670_dvp_emulator_pattern_gen.sv | 43 ++++
 rtl/ov7670_dvp_emulator.sv | 255 +++++++++++++++++++++++++
 tb/tb_ov7670_dvp_emulator.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 DVP transmitter emulator.
package ov7670_pkg;

    // Frame sequencer phases.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VSYNC  = 3'd1,
        BACK   = 3'd2,
        ACTIVE = 3'd3,
        FRONT  = 3'd4
    } state_t;

    // Test pattern selection, encoded exactly as the pattern_sel input.
    typedef enum logic [1:0] {
        PAT_SOLID   = 2'd0,
        PAT_BARS    = 2'd1,
        PAT_XRAMP   = 2'd2,
        PAT_CHECKER = 2'd3
    } pattern_t;

    // RGB565 colour-bar palette, in left-to-right bar order.
    localparam logic [15:0] COLOR_WHITE   = 16'hFFFF;
    localparam logic [15:0] COLOR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] COLOR_CYAN    = 16'h07FF;
    localparam logic [15:0] COLOR_GREEN   = 16'h07E0;
    localparam logic [15:0] COLOR_MAGENTA = 16'hF81F;
    localparam logic [15:0] COLOR_RED     = 16'hF800;
    localparam logic [15:0] COLOR_BLUE    = 16'h001F;
    localparam logic [15:0] COLOR_BLACK   = 16'h0000;

    // Map a bar index (0 = leftmost) to its palette colour.
    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = COLOR_WHITE;
            3'd1:    c = COLOR_YELLOW;
            3'd2:    c = COLOR_CYAN;
            3'd3:    c = COLOR_GREEN;
            3'd4:    c = COLOR_MAGENTA;
            3'd5:    c = COLOR_RED;
            3'd6:    c = COLOR_BLUE;
            3'd7:    c = COLOR_BLACK;
            default: c = COLOR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ov7670_dvp_emulator_pattern_gen.sv
// Combinational test-pattern generator: (x, y, sel) -> RGB565 pixel.
module ov7670_pattern_gen
    import ov7670_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = 640,
    parameter logic [15:0] SOLID_COLOR = 16'hF800
) (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  pattern_t    sel,
    output logic [15:0] pixel
);

    logic [31:0] bar_s;
    logic [2:0]  bar_idx_s;
    logic        unused_y_s;

    // Only y[3] matters (checkerboard); fold the rest away.
    assign unused_y_s = ^{y[15:4], y[2:0]};

    // Eight equal-width bars across the active width; clamp keeps odd widths safe.
    always_comb begin
        bar_s = ({16'h0000, x} * 32'd8) / H_ACTIVE;
        if (bar_s > 32'd7) begin
            bar_idx_s = 3'd7;
        end else begin
            bar_idx_s = bar_s[2:0];
        end
    end

    // Select the pixel value for the latched pattern.
    always_comb begin
        pixel = 16'h0000;
        case (sel)
            PAT_SOLID:   pixel = SOLID_COLOR;
            PAT_BARS:    pixel = bar_color(bar_idx_s);
            PAT_XRAMP:   pixel = x;
            PAT_CHECKER: pixel = (x[3] ^ y[3]) ? COLOR_WHITE : COLOR_BLACK;
            default:     pixel = 16'h0000;
        endcase
    end

endmodule

// File: rtl/ov7670_dvp_emulator.sv
// OV7670 DVP transmitter emulator: pclk divider, frame sequencer and
// registered vsync/href/data outputs driven from synthetic patterns.
module ov7670_dvp_emulator
    import ov7670_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned H_BLANK     = 288,
    parameter int unsigned VSYNC_LINES = 3,
    parameter int unsigned V_BACK      = 17,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned PCLK_DIV    = 2,
    parameter logic [15:0] SOLID_COLOR = 16'hF800
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    output logic        pclk,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  data,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int unsigned LINE_PCLKS = 2 * H_ACTIVE + H_BLANK;
    localparam int unsigned HREF_COLS  = 2 * H_ACTIVE;
    localparam int unsigned MAX_VB     = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
    localparam int unsigned MAX_AF     = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int unsigned MAX_LINES  = (MAX_VB > MAX_AF) ? MAX_VB : MAX_AF;
    localparam int unsigned COL_W      = (LINE_PCLKS > 1) ? $clog2(LINE_PCLKS) : 1;
    localparam int unsigned LINE_W     = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;
    localparam int unsigned DIV_W      = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_PCLKS - 1);
    localparam logic [COL_W:0]   HREF_END = (COL_W + 1)'(HREF_COLS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PCLK_DIV - 1);
    localparam bit               FRAME_OK = (VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT) != 32'd0;

    // Registered state
    logic [DIV_W-1:0]  div_q, div_d;
    logic              pclk_q, pclk_d;
    state_t            state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [LINE_W-1:0] line_q, line_d;
    pattern_t          pattern_q, pattern_d;
    logic              vsync_q, vsync_d;
    logic              href_q, href_d;
    logic [7:0]        data_q, data_d;
    logic              frame_start_q, frame_start_d;
    logic [15:0]       frame_count_q, frame_count_d;

    // Combinational helpers
    logic              fall_tick_s;
    logic              start_s;
    state_t            nxt_s;
    logic [15:0]       x_s;
    logic [15:0]       y_s;
    logic [15:0]       pixel_s;

    // Index of the last line of a phase.
    function automatic logic [LINE_W-1:0] last_line(input state_t s);
        logic [LINE_W-1:0] r;
        case (s)
            VSYNC:   r = LINE_W'(VSYNC_LINES - 1);
            BACK:    r = LINE_W'(V_BACK - 1);
            ACTIVE:  r = LINE_W'(V_ACTIVE - 1);
            FRONT:   r = LINE_W'(V_FRONT - 1);
            default: r = {LINE_W{1'b0}};
        endcase
        return r;
    endfunction

    // Phase that follows s in frame order; IDLE marks end of frame.
    function automatic state_t succ(input state_t s);
        state_t r;
        case (s)
            VSYNC:   r = BACK;
            BACK:    r = ACTIVE;
            ACTIVE:  r = FRONT;
            default: r = IDLE;
        endcase
        return r;
    endfunction

    // First phase at or after s that has at least one line; IDLE if none.
    function automatic state_t first_live(input state_t s);
        logic try_vs;
        logic try_bk;
        logic try_ac;
        logic try_fr;
        state_t r;
        try_vs = (s == VSYNC);
        try_bk = try_vs || (s == BACK);
        try_ac = try_bk || (s == ACTIVE);
        try_fr = try_ac || (s == FRONT);
        if (try_vs && (VSYNC_LINES != 32'd0)) begin
            r = VSYNC;
        end else if (try_bk && (V_BACK != 32'd0)) begin
            r = BACK;
        end else if (try_ac && (V_ACTIVE != 32'd0)) begin
            r = ACTIVE;
        end else if (try_fr && (V_FRONT != 32'd0)) begin
            r = FRONT;
        end else begin
            r = IDLE;
        end
        return r;
    endfunction

    // pclk divider; a fall tick is the clk edge that drives pclk 1->0.
    always_comb begin
        div_d       = div_q;
        pclk_d      = pclk_q;
        fall_tick_s = 1'b0;
        if (div_q == DIV_LAST) begin
            div_d       = {DIV_W{1'b0}};
            pclk_d      = ~pclk_q;
            fall_tick_s = pclk_q;
        end else begin
            div_d       = div_q + DIV_W'(1);
        end
    end

    // Frame sequencer: column/line counters and phase transitions on fall ticks.
    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        line_d        = line_q;
        pattern_d     = pattern_q;
        frame_start_d = 1'b0;
        frame_count_d = frame_count_q;
        start_s       = 1'b0;
        nxt_s         = IDLE;
        if (fall_tick_s) begin
            case (state_q)
                IDLE: begin
                    if (enable && FRAME_OK) begin
                        start_s = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                VSYNC, BACK, ACTIVE, FRONT: begin
                    if (col_q == COL_LAST) begin
                        col_d = {COL_W{1'b0}};
                        if (line_q == last_line(state_q)) begin
                            line_d = {LINE_W{1'b0}};
                            nxt_s  = first_live(succ(state_q));
                            if (nxt_s != IDLE) begin
                                state_d = nxt_s;
                            end else if (enable) begin
                                start_s = 1'b1;
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
                            line_d = line_q + LINE_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    col_d   = {COL_W{1'b0}};
                    line_d  = {LINE_W{1'b0}};
                end
            endcase
            // New frame: latch the pattern, count it and pulse frame_start.
            if (start_s) begin
                state_d       = first_live(VSYNC);
                col_d         = {COL_W{1'b0}};
                line_d        = {LINE_W{1'b0}};
                pattern_d     = pattern_t'(pattern_sel);
                frame_start_d = 1'b1;
                frame_count_d = frame_count_q + 16'd1;
            end else begin
                frame_start_d = 1'b0;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Pixel coordinates for the position about to be driven.
    assign x_s = 16'(col_d >> 1'b1);
    assign y_s = 16'(line_d);

    ov7670_pattern_gen #(
        .H_ACTIVE    (H_ACTIVE),
        .SOLID_COLOR (SOLID_COLOR)
    ) u_pattern_gen (
        .x     (x_s),
        .y     (y_s),
        .sel   (pattern_d),
        .pixel (pixel_s)
    );

    // Sync and data outputs follow the new position, so they only move with pclk falling.
    always_comb begin
        vsync_d = vsync_q;
        href_d  = href_q;
        data_d  = data_q;
        if (fall_tick_s) begin
            vsync_d = (state_d == VSYNC);
            href_d  = (state_d == ACTIVE) && ({1'b0, col_d} < HREF_END);
            if (href_d) begin
                data_d = col_d[0] ? pixel_s[7:0] : pixel_s[15:8];
            end else begin
                data_d = 8'h00;
            end
        end else begin
            vsync_d = vsync_q;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q         <= {DIV_W{1'b0}};
            pclk_q        <= 1'b0;
            state_q       <= IDLE;
            col_q         <= {COL_W{1'b0}};
            line_q        <= {LINE_W{1'b0}};
            pattern_q     <= PAT_SOLID;
            vsync_q       <= 1'b0;
            href_q        <= 1'b0;
            data_q        <= 8'h00;
            frame_start_q <= 1'b0;
            frame_count_q <= 16'h0000;
        end else begin
            div_q         <= div_d;
            pclk_q        <= pclk_d;
            state_q       <= state_d;
            col_q         <= col_d;
            line_q        <= line_d;
            pattern_q     <= pattern_d;
            vsync_q       <= vsync_d;
            href_q        <= href_d;
            data_q        <= data_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign pclk        = pclk_q;
    assign vsync       = vsync_q;
    assign href        = href_q;
    assign data        = data_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_ov7670_dvp_emulator.sv
// Self-checking bench for ov7670_dvp_emulator with a small frame geometry.
module tb_ov7670_dvp_emulator;

    localparam int H_ACTIVE    = 4;
    localparam int V_ACTIVE    = 2;
    localparam int H_BLANK     = 4;
    localparam int VSYNC_LINES = 1;
    localparam int V_BACK      = 1;
    localparam int V_FRONT     = 1;
    localparam int PCLK_DIV    = 1;
    localparam int LINE_PCLKS  = 2 * H_ACTIVE + H_BLANK;
    localparam int FRAME_PCLKS = LINE_PCLKS * (VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT);

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic        pclk;
    logic        vsync;
    logic        href;
    logic [7:0]  data;
    logic        frame_start;
    logic [15:0] frame_count;

    ov7670_dvp_emulator #(
        .H_ACTIVE    (H_ACTIVE),
        .V_ACTIVE    (V_ACTIVE),
        .H_BLANK     (H_BLANK),
        .VSYNC_LINES (VSYNC_LINES),
        .V_BACK      (V_BACK),
        .V_FRONT     (V_FRONT),
        .PCLK_DIV    (PCLK_DIV),
        .SOLID_COLOR (16'hF800)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .pclk        (pclk),
        .vsync       (vsync),
        .href        (href),
        .data        (data),
        .frame_start (frame_start),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, got, want);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] model_pixel(input int x, input int y, input logic [1:0] sel);
        logic [15:0] bars [8];
        logic [15:0] p;
        bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        case (sel)
            2'd0:    p = 16'hF800;
            2'd1:    p = bars[(x * 8) / H_ACTIVE];
            2'd2:    p = 16'(x);
            default: p = (((x / 8) % 2) != ((y / 8) % 2)) ? 16'hFFFF : 16'h0000;
        endcase
        return p;
    endfunction

    // {vsync, href, data} for pclk period p of a frame
    function automatic logic [9:0] model_outs(input int p, input logic [1:0] sel);
        int line, col, act;
        logic vs, hr;
        logic [15:0] pix;
        logic [7:0] d;
        line = p / LINE_PCLKS;
        col  = p % LINE_PCLKS;
        act  = line - VSYNC_LINES - V_BACK;
        vs   = (line < VSYNC_LINES);
        hr   = (act >= 0) && (act < V_ACTIVE) && (col < 2 * H_ACTIVE);
        pix  = model_pixel(col / 2, act, sel);
        d    = hr ? ((col % 2 == 0) ? pix[15:8] : pix[7:0]) : 8'h00;
        return {vs, hr, d};
    endfunction

    logic        m_valid = 1'b0;
    logic        m_pclk = 1'b0;
    logic        m_fall;
    int          m_cnt = 0;
    logic        m_busy = 1'b0;
    int          m_p = 0;
    logic [1:0]  m_sel = 2'd0;
    logic [15:0] m_count = 16'd0;
    logic        m_fs = 1'b0;
    logic [9:0]  m_out = 10'd0;

    always @(posedge clk) begin
        if (!reset) begin
            m_pclk = 1'b0; m_cnt = 0; m_busy = 1'b0; m_p = 0;
            m_sel = 2'd0; m_count = 16'd0; m_fs = 1'b0; m_out = 10'd0;
        end else begin
            m_fs   = 1'b0;
            m_fall = 1'b0;
            m_cnt++;
            if (m_cnt == PCLK_DIV) begin
                m_cnt  = 0;
                m_fall = m_pclk;
                m_pclk = ~m_pclk;
            end
            if (m_fall) begin
                if (m_busy) begin
                    m_p++;
                    if (m_p == FRAME_PCLKS) m_busy = 1'b0;
                end
                if (!m_busy && enable) begin
                    m_busy = 1'b1; m_p = 0; m_sel = pattern_sel;
                    m_count = m_count + 16'd1; m_fs = 1'b1;
                end
                m_out = m_busy ? model_outs(m_p, m_sel) : 10'd0;
            end
        end
        m_valid = 1'b1;
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            check("cycle_outputs",
                  {4'd0, pclk, vsync, href, data, frame_start, frame_count},
                  {4'd0, m_pclk, m_out[9], m_out[8], m_out[7:0], m_fs, m_count});
        end
    end

    // Receiver: bytes sampled at pclk rising while href is high.
    logic [7:0] cap [$];
    always @(posedge pclk) begin
        if (href) cap.push_back(data);
    end

    // ---------------- directed stimulus ----------------
    logic [7:0] exp_ramp  [8];
    logic [7:0] exp_solid [8];
    logic [7:0] exp_bars  [8];

    task automatic wait_fs(input int max_clks, output int waited, output logic found, output logic vs_before);
        logic last_vs;
        last_vs = vsync; found = 1'b0; waited = 0; vs_before = 1'b0;
        while (!found && waited < max_clks) begin
            @(negedge clk);
            waited++;
            if (frame_start) begin
                found = 1'b1;
                vs_before = last_vs;
            end else begin
                last_vs = vsync;
            end
        end
    endtask

    task automatic wait_href(input int max_clks, output logic found);
        int n;
        found = 1'b0; n = 0;
        while (!found && n < max_clks) begin
            @(negedge clk);
            n++;
            if (href) found = 1'b1;
        end
    endtask

    task automatic check_bytes(input string name, input logic [7:0] want [8]);
        check({name, "_len"}, cap.size(), 16);
        for (int i = 0; i < cap.size() && i < 16; i++) begin
            check($sformatf("%s[%0d]", name, i), cap[i], want[i % 8]);
        end
    endtask

    initial begin
        int   toggles, quiet_bad, w, adv;
        logic prev_pclk, found, vsb;

        exp_ramp  = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03};
        exp_solid = '{8'hF8, 8'h00, 8'hF8, 8'h00, 8'hF8, 8'h00, 8'hF8, 8'h00};
        // bar = x*8/4 -> white, cyan, magenta, blue
        exp_bars  = '{8'hFF, 8'hFF, 8'h07, 8'hFF, 8'hF8, 8'h1F, 8'h00, 8'h1F};

        // Reset and idle
        repeat (3) @(negedge clk);
        check("reset_outputs", {4'd0, pclk, vsync, href, data, frame_start, frame_count}, 32'd0);
        reset = 1'b1;
        prev_pclk = pclk; toggles = 0; quiet_bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (pclk != prev_pclk) toggles++;
            prev_pclk = pclk;
            if (vsync || href || frame_start) quiet_bad++;
        end
        check("idle_pclk_toggles", toggles, 100);
        check("idle_quiet", quiet_bad, 0);

        // Frame 1: x-ramp, timing
        pattern_sel = 2'd2;
        enable = 1'b1;
        wait_fs(10, w, found, vsb);
        check("fs1_seen", {31'd0, found}, 32'd1);
        check("fs1_vsync_rise", {30'd0, vsb, vsync}, 32'd1);
        check("fs1_count", frame_count, 32'd1);
        cap.delete();
        adv = 0;
        do begin
            @(negedge clk);
            adv++;
            if (adv == 1) check("fs_one_clk", {31'd0, frame_start}, 32'd0);
        end while (vsync && adv < 500);
        check("vsync_high_clks", adv, 24);
        wait_fs(300, w, found, vsb);
        check("fs2_seen", {31'd0, found}, 32'd1);
        check("frame_period_clks", adv + w, 120);
        check("fs2_vsync_rise", {30'd0, vsb, vsync}, 32'd1);
        check("fs2_count", frame_count, 32'd2);
        check_bytes("ramp_f1", exp_ramp);

        // Frame 2 latched ramp; selector change now applies to frame 3
        cap.delete();
        pattern_sel = 2'd0;
        wait_fs(300, w, found, vsb);
        check("fs3_count", frame_count, 32'd3);
        check_bytes("ramp_f2", exp_ramp);

        // Frame 3 solid; switch to bars mid-ACTIVE
        cap.delete();
        wait_href(100, found);
        check("href_seen_f3", {31'd0, found}, 32'd1);
        repeat (2) @(negedge clk);
        pattern_sel = 2'd1;
        wait_fs(300, w, found, vsb);
        check("fs4_count", frame_count, 32'd4);
        check_bytes("solid_f3", exp_solid);

        // Frame 4 bars; drop enable during VSYNC
        cap.delete();
        repeat (4) @(negedge clk);
        check("in_vsync_f4", {31'd0, vsync}, 32'd1);
        enable = 1'b0;
        wait_fs(400, w, found, vsb);
        check("no_fs_after_drop", {31'd0, found}, 32'd0);
        check_bytes("bars_f4", exp_bars);
        check("count_after_drop", frame_count, 32'd4);
        check("idle_after_drop", {30'd0, vsync, href}, 32'd0);

        // Reset abort mid-ACTIVE
        enable = 1'b1;
        wait_fs(10, w, found, vsb);
        check("fs5_count", frame_count, 32'd5);
        wait_href(100, found);
        check("href_seen_f5", {31'd0, found}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("reset_abort", {4'd0, pclk, vsync, href, data, frame_start, frame_count}, 32'd0);
        reset = 1'b1;
        enable = 1'b0;
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
